// File: rtl/spi_tx_core.sv
// Transmit-only SPI master: shifts a latched word out MSB-first on o_mosi with a
// generated o_sck (idle low, programmable half-period) and frames it with o_start/o_finish.
module spi_tx_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int DELAY_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [3:0]             i_data_length,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [DELAY_WIDTH-1:0] i_delay,
  output logic                   o_mosi,
  output logic                   o_sck,
  output logic                   o_start,
  output logic                   o_finish
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [4:0]             LEN_MAX = 5'(DATA_WIDTH);
  localparam logic [DELAY_WIDTH-1:0] DLY_ONE = DELAY_WIDTH'(1);
  localparam logic [IDX_W-1:0]       IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, SCK_HIGH, SCK_LOW} state_t;

  state_t                 r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_data, w_data_nxt;
  logic [DELAY_WIDTH-1:0] r_delay, w_delay_nxt;
  logic [DELAY_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]       r_bit_idx, w_bit_idx_nxt;
  logic                   r_mosi, w_mosi_nxt;
  logic                   r_sck, w_sck_nxt;
  logic                   r_start, w_start_nxt;
  logic                   r_finish, w_finish_nxt;

  // Out-of-range operands are folded to their safe values before being latched.
  logic [DELAY_WIDTH-1:0] w_delay_eff;
  logic [4:0]             w_len_in, w_len_eff;
  logic [IDX_W-1:0]       w_idx_init, w_idx_dec;
  logic                   w_cnt_done;

  assign w_delay_eff = (i_delay == '0) ? DLY_ONE : i_delay;
  assign w_len_in    = {1'b0, i_data_length};
  assign w_len_eff   = ((w_len_in == 5'd0) || (w_len_in > LEN_MAX)) ? LEN_MAX : w_len_in;
  assign w_idx_init  = IDX_W'(w_len_eff - 5'd1);
  assign w_idx_dec   = r_bit_idx - IDX_ONE;
  assign w_cnt_done  = (r_cnt == '0);

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: each combinational block assigns a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (i_start)    w_state_nxt = SCK_HIGH;
      SCK_HIGH: if (w_cnt_done) w_state_nxt = SCK_LOW;
      SCK_LOW:  if (w_cnt_done) w_state_nxt = (r_bit_idx == '0) ? IDLE : SCK_HIGH;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // The counter is preloaded with D-1 so each SCK phase lasts exactly D cycles.
  always_comb begin
    w_data_nxt    = r_data;
    w_delay_nxt   = r_delay;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_mosi_nxt    = r_mosi;
    w_sck_nxt     = r_sck;
    w_start_nxt   = 1'b0;
    w_finish_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_sck_nxt  = 1'b0;
        w_mosi_nxt = 1'b0;
        if (i_start) begin
          w_data_nxt    = i_data;
          w_delay_nxt   = w_delay_eff;
          w_cnt_nxt     = w_delay_eff - DLY_ONE;
          w_bit_idx_nxt = w_idx_init;
          w_mosi_nxt    = i_data[w_idx_init];
          w_sck_nxt     = 1'b1;
          w_start_nxt   = 1'b1;
        end
      end
      SCK_HIGH: begin
        if (w_cnt_done) begin
          w_sck_nxt = 1'b0;
          w_cnt_nxt = r_delay - DLY_ONE;
        end else begin
          w_cnt_nxt = r_cnt - DLY_ONE;
        end
      end
      SCK_LOW: begin
        if (!w_cnt_done) begin
          w_cnt_nxt = r_cnt - DLY_ONE;
        end else if (r_bit_idx == '0) begin
          w_mosi_nxt   = 1'b0;
          w_finish_nxt = 1'b1;
        end else begin
          w_bit_idx_nxt = w_idx_dec;
          w_mosi_nxt    = r_data[w_idx_dec];
          w_sck_nxt     = 1'b1;
          w_cnt_nxt     = r_delay - DLY_ONE;
        end
      end
      default: begin
        w_sck_nxt  = 1'b0;
        w_mosi_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: the word register is a plain flop bank, so clearing it on reset is cheap and
  // keeps a reset-aborted transfer from leaving stale data behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data    <= '0;
      r_delay   <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_mosi    <= 1'b0;
      r_sck     <= 1'b0;
      r_start   <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_data    <= w_data_nxt;
      r_delay   <= w_delay_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_mosi    <= w_mosi_nxt;
      r_sck     <= w_sck_nxt;
      r_start   <= w_start_nxt;
      r_finish  <= w_finish_nxt;
    end
  end

  assign o_mosi   = r_mosi;
  assign o_sck    = r_sck;
  assign o_start  = r_start;
  assign o_finish = r_finish;

endmodule

// File: tb/tb_spi_tx_core.sv
// Directed bench for spi_tx_core: a negedge-of-SCK receiver model plus timing monitors,
// a table of single transfers, and hand-written back-to-back, busy-input and reset sequences.
module tb_spi_tx_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [3:0]  i_data_length = 4'd0;
  logic [7:0]  i_data = 8'h00;
  logic [31:0] i_delay = 32'd0;
  logic        o_mosi, o_sck, o_start, o_finish;

  spi_tx_core #(.DATA_WIDTH(8), .DELAY_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_data_length(i_data_length),
    .i_data(i_data), .i_delay(i_delay), .o_mosi(o_mosi), .o_sck(o_sck),
    .o_start(o_start), .o_finish(o_finish)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected transfer shape, set by the stimulus before each launch.
  int       exp_d = 1, exp_bits = 8, exp_lat = 16;
  logic [7:0] exp_word = 8'h00;

  // Monitor: receiver shift register (slave samples on SCK fall), phase lengths, framing.
  int   cyc = 0, run = 0, pulses = 0;
  int   start_cnt = 0, finish_cnt = 0, start_cyc = 0, finish_cyc = -100, last_lat = 0;
  int   last_pulses = 0, min_gap = 1000;
  int   run_bad = 0, mosi_bad = 0, fin_bad = 0, overlap = 0, lat_bad = 0, rx_bad = 0, pulse_bad = 0;
  logic [7:0] rx = 8'h00, last_rx = 8'h00;
  logic prev_sck = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_sck && !o_sck) begin
      if (run != exp_d) run_bad++;
      if (o_mosi != prev_mosi) mosi_bad++;
      rx  = {rx[6:0], o_mosi};
      run = 1;
    end else if (!prev_sck && o_sck) begin
      if (!o_start && run != exp_d) run_bad++;
      pulses++;
      run = 1;
    end else begin
      run++;
    end
    if (o_start) begin
      start_cnt++;
      if (cyc - finish_cyc < min_gap) min_gap = cyc - finish_cyc;
      start_cyc = cyc;
      pulses    = 1;
      rx        = 8'h00;
    end
    if (o_finish) begin
      finish_cnt++;
      finish_cyc  = cyc;
      last_lat    = cyc - start_cyc;
      last_rx     = rx;
      last_pulses = pulses;
      if (last_lat != exp_lat)  lat_bad++;
      if (rx != exp_word)       rx_bad++;
      if (pulses != exp_bits)   pulse_bad++;
      if (o_sck || o_mosi)      fin_bad++;
    end
    if (o_start && o_finish) overlap++;
    prev_sck  = o_sck;
    prev_mosi = o_mosi;
  end

  task automatic launch(input logic [3:0] len, input logic [7:0] data, input logic [31:0] dly);
    @(negedge clk);
    i_data_length = len;
    i_data        = data;
    i_delay       = dly;
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_finish(input int target, input string name);
    for (int i = 0; i < 3000 && finish_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, finish_cnt, target);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  len;
    logic [7:0]  data;
    logic [31:0] delay;
    int          bits;
    int          d;
    logic [7:0]  word;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int s0, f0, rb0, mb0, fb0, ov0, lb0, xb0, pb0;

    vecs[0] = '{"len8_d10_32", 4'd8,  8'h32, 32'd10, 8, 10, 8'h32, 160};
    vecs[1] = '{"len4_d1_a5",  4'd4,  8'hA5, 32'd1,  4, 1,  8'h05, 8};
    vecs[2] = '{"d0_l0_81",    4'd0,  8'h81, 32'd0,  8, 1,  8'h81, 16};
    vecs[3] = '{"len1_d2_01",  4'd1,  8'h01, 32'd2,  1, 2,  8'h01, 4};
    vecs[4] = '{"len12_d3_6c", 4'd12, 8'h6C, 32'd3,  8, 3,  8'h6C, 48};
    vecs[5] = '{"len5_d2_f3",  4'd5,  8'hF3, 32'd2,  5, 2,  8'h13, 20};

    // Reset state
    #3;
    check("rst_sck", o_sck, 0);
    check("rst_mosi", o_mosi, 0);
    check("rst_start", o_start, 0);
    check("rst_finish", o_finish, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      exp_d = vecs[k].d; exp_bits = vecs[k].bits; exp_word = vecs[k].word; exp_lat = vecs[k].lat;
      s0 = start_cnt; f0 = finish_cnt; rb0 = run_bad; mb0 = mosi_bad; fb0 = fin_bad; ov0 = overlap;
      launch(vecs[k].len, vecs[k].data, vecs[k].delay);
      wait_finish(f0 + 1, {vecs[k].name, "_finish"});
      repeat (3) @(negedge clk);
      #1;
      check({vecs[k].name, "_starts"}, start_cnt - s0, 1);
      check({vecs[k].name, "_latency"}, last_lat, vecs[k].lat);
      check({vecs[k].name, "_rx"}, last_rx, vecs[k].word);
      check({vecs[k].name, "_pulses"}, last_pulses, vecs[k].bits);
      check({vecs[k].name, "_phase_len"}, run_bad - rb0, 0);
      check({vecs[k].name, "_mosi_at_fall"}, mosi_bad - mb0, 0);
      check({vecs[k].name, "_idle_after"}, fin_bad - fb0, 0);
      check({vecs[k].name, "_overlap"}, overlap - ov0, 0);
    end

    // i_start held high: three back-to-back transfers
    exp_d = 2; exp_bits = 3; exp_word = 8'h05; exp_lat = 12;
    s0 = start_cnt; f0 = finish_cnt; rb0 = run_bad; fb0 = fin_bad; ov0 = overlap;
    lb0 = lat_bad; xb0 = rx_bad; pb0 = pulse_bad;
    min_gap = 1000;
    @(negedge clk);
    i_data_length = 4'd3; i_data = 8'h05; i_delay = 32'd2; i_start = 1'b1;
    for (int i = 0; i < 500 && start_cnt < s0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    i_start = 1'b0;
    wait_finish(f0 + 3, "held_finish");
    repeat (10) @(negedge clk);
    #1;
    check("held_starts", start_cnt - s0, 3);
    check("held_finishes", finish_cnt - f0, 3);
    check("held_gap_ge1", min_gap >= 1, 1);
    check("held_latency", lat_bad - lb0, 0);
    check("held_rx", rx_bad - xb0, 0);
    check("held_pulses", pulse_bad - pb0, 0);
    check("held_phase_len", run_bad - rb0, 0);
    check("held_idle_after", fin_bad - fb0, 0);
    check("held_overlap", overlap - ov0, 0);

    // Input changes and a start pulse while busy
    exp_d = 2; exp_bits = 8; exp_word = 8'hC3; exp_lat = 32;
    s0 = start_cnt; f0 = finish_cnt; rb0 = run_bad;
    launch(4'd8, 8'hC3, 32'd2);
    repeat (5) @(negedge clk);
    i_data = 8'h00; i_delay = 32'd7; i_data_length = 4'd3; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_finish(f0 + 1, "busy_finish");
    repeat (3) @(negedge clk);
    #1;
    check("busy_starts", start_cnt - s0, 1);
    check("busy_rx", last_rx, 8'hC3);
    check("busy_latency", last_lat, 32);
    check("busy_phase_len", run_bad - rb0, 0);

    // Reset mid-transfer
    exp_d = 4; exp_bits = 8; exp_word = 8'hFF; exp_lat = 64;
    f0 = finish_cnt;
    launch(4'd8, 8'hFF, 32'd4);
    repeat (9) @(negedge clk);
    check("abort_pre_sck", o_sck, 1);
    check("abort_pre_mosi", o_mosi, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sck", o_sck, 0);
    check("abort_mosi", o_mosi, 0);
    check("abort_start", o_start, 0);
    check("abort_finish", o_finish, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_finish", finish_cnt - f0, 0);

    exp_d = 1; exp_bits = 2; exp_word = 8'h02; exp_lat = 4;
    s0 = start_cnt; f0 = finish_cnt; rb0 = run_bad;
    launch(4'd2, 8'h02, 32'd1);
    wait_finish(f0 + 1, "post_rst_finish");
    repeat (3) @(negedge clk);
    #1;
    check("post_rst_starts", start_cnt - s0, 1);
    check("post_rst_rx", last_rx, 8'h02);
    check("post_rst_latency", last_lat, 4);
    check("post_rst_phase_len", run_bad - rb0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
